// File: rtl/cache_arbiter_pkg.sv
// Shared types for the LC-3b cache arbiter slice: word/line types, the
// arbiter state encoding and default bus widths.
package cache_arbiter_pkg;

    localparam int unsigned LC3B_LINE_WIDTH = 128;
    localparam int unsigned LC3B_ADDR_WIDTH = 16;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        arb_idle,
        arb_serve_i,
        arb_serve_d
    } lc3b_arb_state;

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM: decides which L1 cache owns the memory port and holds the
// grant until memory responds. Optional macro CACHE_ARB_ROUND_ROBIN_EN
// replaces fixed dcache priority with alternating priority on contention.
module cache_arbiter_control
    import cache_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_read,
    input  logic d_read,
    input  logic d_write,
    input  logic pmem_resp,
    output logic grant_i,
    output logic grant_d
);

    lc3b_arb_state state;
    lc3b_arb_state next_state;
    logic          d_req;
    logic          prefer_i;

    assign d_req = d_read | d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    // 1 = dcache was served last, 0 = icache was served last
    logic last_grant;

    assign prefer_i = last_grant;

    // Record who was granted on every entry into a serve state
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b0;
        end else if (state == arb_idle) begin
            if (next_state == arb_serve_i) begin
                last_grant <= 1'b0;
            end else if (next_state == arb_serve_d) begin
                last_grant <= 1'b1;
            end
        end
    end
`else
    assign prefer_i = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= arb_idle;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and grant decode; a grant is held until pmem_resp
    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        unique case (state)
            arb_idle: begin
                if (d_req && i_read) begin
                    next_state = prefer_i ? arb_serve_i : arb_serve_d;
                end else if (d_req) begin
                    next_state = arb_serve_d;
                end else if (i_read) begin
                    next_state = arb_serve_i;
                end
            end
            arb_serve_i: begin
                grant_i = 1'b1;
                if (pmem_resp) begin
                    next_state = arb_idle;
                end
            end
            arb_serve_d: begin
                grant_d = 1'b1;
                if (pmem_resp) begin
                    next_state = arb_idle;
                end
            end
            default: begin
                next_state = arb_idle;
            end
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the icache and dcache. The
// control sub-module picks the owner; this level steers command, address
// and data to memory and returns the response only to the owner.
// Optional macro CACHE_ARB_ROUND_ROBIN_EN (see cache_arbiter_control).
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = LC3B_LINE_WIDTH,
    parameter int unsigned ADDR_WIDTH = LC3B_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    logic grant_i;
    logic grant_d;

    cache_arbiter_control u_control (
        .clk       (clk),
        .reset     (reset),
        .i_read    (i_read),
        .d_read    (d_read),
        .d_write   (d_write),
        .pmem_resp (pmem_resp),
        .grant_i   (grant_i),
        .grant_d   (grant_d)
    );

    // Command/address/data steering toward memory; idle drives all zeros
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        if (grant_i) begin
            pmem_read    = 1'b1;
            pmem_address = i_address;
        end else if (grant_d) begin
            pmem_read    = d_read;
            pmem_write   = d_write;
            pmem_address = d_address;
            pmem_wdata   = d_wdata;
        end
    end

    // Response/data return, visible only to the granted requester
    always_comb begin
        i_resp  = grant_i & pmem_resp;
        d_resp  = grant_d & pmem_resp;
        i_rdata = grant_i ? pmem_rdata : '0;
        d_rdata = grant_d ? pmem_rdata : '0;
    end

endmodule
